// File: rtl/pkt_hdr_gen_if.sv
// pkt_hdr_gen_if: header-generator bus.
// The master drives start and the header fields. The slave returns the nibble stream
// (d_out, strobe, valid) and its status (busy, done, frame_len).
interface pkt_hdr_gen_if;
  logic        start;
  logic [47:0] Dstmac;
  logic [47:0] Srcmac;
  logic        vlan;
  logic [15:0] vlan_tci;
  logic [15:0] Ethproto;
  logic [7:0]  Ipproto;
  logic [31:0] srcip4;
  logic [31:0] dstip4;
  logic [15:0] Srcport;
  logic [15:0] Dstport;
  logic [15:0] icmp;
  logic [3:0]  d_out;
  logic        strobe;
  logic        valid;
  logic        busy;
  logic        done;
  logic [5:0]  frame_len;
  modport master (
    output start, Dstmac, Srcmac, vlan, vlan_tci, Ethproto, Ipproto, srcip4, dstip4,
           Srcport, Dstport, icmp,
    input  d_out, strobe, valid, busy, done, frame_len
  );
  modport slave (
    input  start, Dstmac, Srcmac, vlan, vlan_tci, Ethproto, Ipproto, srcip4, dstip4,
           Srcport, Dstport, icmp,
    output d_out, strobe, valid, busy, done, frame_len
  );
endinterface

// File: rtl/pkt_hdr_gen.sv
// pkt_hdr_gen: latches header fields on start, computes the IPv4 checksum and
// serialises an Ethernet/VLAN/IPv4/L4 header as a nibble stream.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - pkt_hdr_gen_if.slave: the field inputs plus start; the outputs
//           d_out, strobe, valid, busy, done and frame_len
module pkt_hdr_gen #(
  parameter logic [7:0] TTL = 8'd64,
  parameter int         IFG = 2
) (
  input logic          clk,
  input logic          reset,
  pkt_hdr_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CSUM, SEND, GAP} state_t;
  state_t r_state;
  logic [335:0] r_sh;
  logic [15:0]  r_sum;
  logic [3:0]   r_idx;
  logic [6:0]   r_cnt;
  logic [7:0]   r_gap;
  logic         r_vlan;
  logic [5:0]   r_len;
  logic [3:0]   r_d_out;
  logic         r_strobe, r_valid, r_busy, r_done;
  logic         w_ipf;
  logic [5:0]   w_l4len, w_len;
  logic [31:0]  w_l4;
  logic [159:0] w_ip, w_iph, w_iph_sh;
  logic [335:0] w_hdr, w_ins;
  logic [7:0]   w_shift;
  logic [15:0]  w_word, w_fold;
  logic [16:0]  w_s17;
  logic [6:0]   w_last;
  always_comb begin
    w_ipf    = bus.Ethproto == 16'h0800;
    w_l4len  = (bus.Ipproto == 8'h06 || bus.Ipproto == 8'h11) ? 6'd4 : bus.Ipproto == 8'h01 ? 6'd2 : 6'd0;
    w_len    = 6'd14 + (bus.vlan ? 6'd4 : 6'd0) + (w_ipf ? 6'd20 + w_l4len : 6'd0);
    w_l4     = (bus.Ipproto == 8'h06 || bus.Ipproto == 8'h11) ? {bus.Srcport, bus.Dstport} :
               bus.Ipproto == 8'h01 ? {bus.icmp, 16'd0} : 32'd0;
    w_ip     = {16'h4500, 10'd0, 6'd20 + w_l4len, 32'd0, TTL, bus.Ipproto, 16'd0, bus.srcip4, bus.dstip4};
    // Header is left-aligned; bytes beyond frame_len are never shifted out.
    w_hdr    = bus.vlan ? {bus.Dstmac, bus.Srcmac, 16'h8100, bus.vlan_tci, bus.Ethproto, w_ip, w_l4} :
                          {bus.Dstmac, bus.Srcmac, bus.Ethproto, w_ip, w_l4, 32'd0};
    // During CSUM the IPv4 header already sits in the shift register with a zero checksum.
    w_iph    = r_vlan ? r_sh[191:32] : r_sh[223:64];
    w_shift  = 8'd16 * (8'd9 - {4'd0, r_idx});
    w_iph_sh = w_iph >> w_shift;
    w_word   = w_iph_sh[15:0];
    w_s17    = {1'b0, r_sum} + {1'b0, w_word};
    w_fold   = w_s17[15:0] + {15'd0, w_s17[16]};
    w_ins    = r_vlan ? {r_sh[335:112], ~w_fold, r_sh[95:0]} : {r_sh[335:144], ~w_fold, r_sh[127:0]};
    w_last   = {r_len, 1'b0} - 7'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sh     <= '0;
      r_sum    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_vlan   <= 1'b0;
      r_len    <= '0;
      r_d_out  <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_vlan <= bus.vlan;
            r_len  <= w_len;
            r_sum  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_ipf) begin
              r_sh    <= w_hdr;
              r_state <= CSUM;
            end else begin
              r_sh     <= w_hdr << 4;
              r_d_out  <= w_hdr[335:332];
              r_strobe <= 1'b1;
              r_valid  <= 1'b1;
              r_state  <= SEND;
            end
          end
        end
        CSUM: begin
          r_sum <= w_fold;
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd9) begin
            r_sh     <= w_ins << 4;
            r_d_out  <= w_ins[335:332];
            r_strobe <= 1'b1;
            r_valid  <= 1'b1;
            r_state  <= SEND;
          end
        end
        SEND: begin
          r_strobe <= 1'b0;
          if (r_cnt == w_last) begin
            r_d_out <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_gap   <= '0;
            r_busy  <= IFG != 0;
            r_state <= (IFG == 0) ? IDLE : GAP;
          end else begin
            r_d_out <= r_sh[335:332];
            r_sh    <= r_sh << 4;
            r_cnt   <= r_cnt + 7'd1;
          end
        end
        GAP: begin
          r_done <= 1'b0;
          if (r_gap == 8'(IFG - 1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.d_out     = r_d_out;
  assign bus.strobe    = r_strobe;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.frame_len = r_len;
endmodule

// File: tb/tb_pkt_hdr_gen.sv
// tb_pkt_hdr_gen: directed and random frames checked against a byte-level header model.
module tb_pkt_hdr_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  pkt_hdr_gen_if bus();
  pkt_hdr_gen #(.TTL(8'd64), .IFG(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] bq[$];
  logic [3:0] nq[$];
  int exp_len;
  bit exp_ip;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_case(input logic [47:0] dst, input logic [47:0] src, input logic vl,
                          input logic [15:0] tci, input logic [15:0] eth, input logic [7:0] pr,
                          input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] ic);
    bus.Dstmac = dst; bus.Srcmac = src; bus.vlan = vl; bus.vlan_tci = tci;
    bus.Ethproto = eth; bus.Ipproto = pr; bus.srcip4 = sip; bus.dstip4 = dip;
    bus.Srcport = sp; bus.Dstport = dp; bus.icmp = ic;
  endtask
  task automatic rand_fields();
    logic [15:0] eths[4];
    logic [7:0]  prs[4];
    eths = '{16'h0800, 16'h0800, 16'h86DD, 16'($urandom)};
    prs  = '{8'h06, 8'h11, 8'h01, 8'($urandom)};
    set_case({16'($urandom), $urandom}, {16'($urandom), $urandom}, 1'($urandom), 16'($urandom),
             eths[$urandom_range(0, 3)], prs[$urandom_range(0, 3)], $urandom, $urandom,
             16'($urandom), 16'($urandom), 16'($urandom));
  endtask
  task automatic push16(input logic [15:0] w);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endtask
  task automatic model();
    logic [15:0] w[10];
    int l4, s;
    bq.delete();
    nq.delete();
    for (int i = 5; i >= 0; i--) bq.push_back(bus.Dstmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) bq.push_back(bus.Srcmac[8*i +: 8]);
    if (bus.vlan) begin
      push16(16'h8100);
      push16(bus.vlan_tci);
    end
    push16(bus.Ethproto);
    exp_ip = bus.Ethproto == 16'h0800;
    if (exp_ip) begin
      l4 = (bus.Ipproto == 8'd6 || bus.Ipproto == 8'd17) ? 4 : (bus.Ipproto == 8'd1) ? 2 : 0;
      w = '{16'h4500, 16'(20 + l4), 16'h0, 16'h0, {8'd64, bus.Ipproto}, 16'h0,
            bus.srcip4[31:16], bus.srcip4[15:0], bus.dstip4[31:16], bus.dstip4[15:0]};
      s = 0;
      for (int i = 0; i < 10; i++) s += int'(w[i]);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      w[5] = ~16'(s);
      for (int i = 0; i < 10; i++) push16(w[i]);
      if (l4 == 4) begin
        push16(bus.Srcport);
        push16(bus.Dstport);
      end else if (l4 == 2) push16(bus.icmp);
    end
    exp_len = bq.size();
    foreach (bq[i]) begin
      nq.push_back(bq[i][7:4]);
      nq.push_back(bq[i][3:0]);
    end
  endtask
  task automatic run_frame(input bit spam);
    int cyc;
    model();
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk("busy_after_accept", bus.busy, 1);
    if (!spam) bus.start = 1'b0;
    while (bus.strobe !== 1'b1 && cyc < 40) begin
      if (spam) rand_fields();
      @(negedge clk);
      cyc++;
    end
    chk("first_nibble_latency", cyc, exp_ip ? 11 : 1);
    chk("frame_len", bus.frame_len, exp_len);
    for (int i = 0; i < nq.size(); i++) begin
      chk($sformatf("nibble%0d", i), {bus.valid, bus.strobe, bus.d_out}, {1'b1, 1'(i == 0), nq[i]});
      if (spam) rand_fields();
      @(negedge clk);
    end
    chk("gap1_done", {bus.valid, bus.strobe, bus.done, bus.busy, bus.d_out}, {4'b0011, 4'h0});
    @(negedge clk);
    chk("gap2", {bus.valid, bus.strobe, bus.done, bus.busy}, 4'b0001);
    @(negedge clk);
    chk("idle_after_ifg", {bus.valid, bus.strobe, bus.done, bus.busy}, 4'b0000);
    bus.start = 1'b0;
    @(negedge clk);
    chk("no_queued_frame", {bus.valid, bus.busy}, 2'b00);
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    set_case(48'h0, 48'h0, 1'b0, 16'h0, 16'h0, 8'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0);
    #12;
    chk("reset_outputs", {bus.d_out, bus.strobe, bus.valid, bus.busy, bus.done, bus.frame_len}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_case(48'hFFFFFFFFFFFF, 48'h001122334455, 1'b0, 16'h0, 16'h88CC, 8'h06,
             32'h01020304, 32'h05060708, 16'h1, 16'h2, 16'h3);
    run_frame(1'b0);
    set_case(48'h010203040506, 48'h0A0B0C0D0E0F, 1'b1, 16'h0064, 16'h0800, 8'h11,
             32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h0050, 16'h0);
    model();
    chk("case2_csum", {bq[28], bq[29]}, 16'hF981);
    chk("case2_tlen", {bq[20], bq[21]}, 16'h0018);
    run_frame(1'b0);
    set_case(48'h111111111111, 48'h222222222222, 1'b0, 16'h0, 16'h0800, 8'h01,
             32'h0A000001, 32'h0A000002, 16'h0, 16'h0, 16'h0800);
    model();
    chk("case3_tlen", {bq[16], bq[17]}, 16'h0016);
    chk("case3_tail", {nq[68], nq[69], nq[70], nq[71]}, 16'h0800);
    run_frame(1'b0);
    set_case(48'h010203040506, 48'h0A0B0C0D0E0F, 1'b1, 16'h0064, 16'h0800, 8'h11,
             32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h0050, 16'h0);
    run_frame(1'b1);
    model();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.strobe !== 1'b1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("async_reset_abort", {bus.valid, bus.strobe, bus.busy, bus.done, bus.d_out, bus.frame_len}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(1'b0);
    for (int k = 0; k < 12; k++) begin
      rand_fields();
      run_frame(1'(k % 4 == 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
